// File: rtl/filter_stimulus_player.sv
// Sample-table player feeding the adaptive filter input stream.
// Plays a Q8.6 table at a programmable rate and drives the filter mode line.
module filter_stimulus_player #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 14,
  parameter int IVL_W  = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [$clog2(DEPTH):0]     length,
  input  logic [IVL_W-1:0]           interval,
  input  logic                       mode_init,
  input  logic [$clog2(DEPTH):0]     switch_idx,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  output logic                       m_ctrl,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW-1:0]    r_idx;
  logic [IVL_W-1:0] r_cnt;
  logic [IVL_W-1:0] r_ivl;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_sw;
  logic             r_mode;
  logic             r_fin;

  logic [LW-1:0]    w_len_clamp;
  logic             w_start;
  logic             w_fire;
  logic             w_last;
  logic             w_ctrl;

  // Write port only; the read side is the output register below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_len_clamp = (length > LW'(DEPTH))
                     ? LW'(DEPTH) : length;

  assign w_start = start && !stop
                && (length != '0)
                && (r_state != S_PLAY);

  // r_fin marks the cycle holding the final strobe of a pass.
  assign w_fire = (r_state == S_PLAY)
               && !stop && !r_fin
               && (r_cnt == '0);

  assign w_last = ({1'b0, r_idx} == r_len - LW'(1));

  assign w_ctrl = ({1'b0, r_idx} < r_sw)
                ? r_mode : ~r_mode;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (r_fin) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_ivl    <= '0;
      r_len    <= '0;
      r_sw     <= '0;
      r_mode   <= 1'b0;
      r_fin    <= 1'b0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_ctrl   <= 1'b0;
    end else begin
      m_tvalid <= w_fire;
      if (w_start) begin
        r_idx  <= '0;
        r_cnt  <= '0;
        r_ivl  <= interval;
        r_len  <= w_len_clamp;
        r_sw   <= switch_idx;
        r_mode <= mode_init;
        r_fin  <= 1'b0;
      end else if (w_fire) begin
        m_tdata <= r_mem[r_idx];
        m_ctrl  <= w_ctrl;
        r_cnt   <= r_ivl;
        if (w_last) begin
          r_idx <= '0;
          r_fin <= !loop_en;
        end else begin
          r_idx <= r_idx + AW'(1);
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - IVL_W'(1);
      end
    end
  end

  assign busy = (r_state == S_PLAY);
  assign done = (r_state == S_DONE);

endmodule
